// File: rtl/dmem_operand_sequencer_pkg.sv
// Shared widths, FSM state encoding and helpers for the data-RAM operand sequencer.
package dmem_operand_sequencer_pkg;

    // Data word width and RAM depth of the calculator's data memory.
    localparam int COL   = 16;
    localparam int ROW_D = 256;

    // 3-bit encoding, 7 states; values are fixed so a bench can probe them.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_A     = 3'd1,
        ST_RD_B     = 3'd2,
        ST_CAP_B    = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_WR       = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // ceil(log2(limit+1)), never narrower than one bit so TIMEOUT=0 still elaborates.
    function automatic int timer_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_operand_sequencer_wait_timer.sv
// Saturating cycle counter that bounds how long the sequencer waits for the ALU.
module dmem_operand_sequencer_wait_timer
    import dmem_operand_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = timer_width(TIMEOUT);

    logic [CNT_W-1:0] count_reg;

    // Count enabled cycles, hold at TIMEOUT, restart from zero on clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != CNT_W'(TIMEOUT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Expiry fires in the cycle whose closing edge brings the count to TIMEOUT,
    // so the owner leaves after exactly TIMEOUT enabled cycles.
    generate
        if (TIMEOUT == 0) begin : g_no_limit
            assign expired = 1'b0;
        end else begin : g_limit
            assign expired = enable && (count_reg == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/dmem_operand_sequencer.sv
// Reads operands A and B from the single-port data RAM, hands them to the ALU,
// waits for the result and writes it back. All outputs are registered.
module dmem_operand_sequencer
    import dmem_operand_sequencer_pkg::*;
#(
    parameter int DATA_W  = COL,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_r,
    output logic              busy,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              ops_valid,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              done,
    output logic              err
);

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr_b_reg, addr_b_next;
    logic [ADDR_W-1:0] addr_r_reg, addr_r_next;

    logic              busy_reg, busy_next;
    logic              ops_valid_reg, ops_valid_next;
    logic              mem_we_reg, mem_we_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [DATA_W-1:0] op_a_reg, op_a_next;
    logic [DATA_W-1:0] op_b_reg, op_b_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_din_reg, mem_din_next;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    assign timer_enable = (state_reg == ST_WAIT_RES);

    dmem_operand_sequencer_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Next state plus next value of every output register; outputs are derived
    // from the state being entered so they line up with that state's cycle.
    always_comb begin
        state_next    = state_reg;
        addr_b_next   = addr_b_reg;
        addr_r_next   = addr_r_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        mem_addr_next = mem_addr_reg;
        mem_din_next  = mem_din_reg;
        err_next      = 1'b0;
        timer_clear   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // res_valid is not looked at here, so a coincident strobe is dropped.
                if (start) begin
                    mem_addr_next = addr_a;
                    addr_b_next   = addr_b;
                    addr_r_next   = addr_r;
                    state_next    = ST_RD_A;
                end
            end
            ST_RD_A: begin
                mem_addr_next = addr_b_reg;
                state_next    = ST_RD_B;
            end
            ST_RD_B: begin
                // RAM output now holds mem[a] from the RD_A edge.
                op_a_next  = mem_dout;
                state_next = ST_CAP_B;
            end
            ST_CAP_B: begin
                op_b_next   = mem_dout;
                timer_clear = 1'b1;
                state_next  = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                // A result in the last allowed cycle still wins over the timeout.
                if (res_valid) begin
                    mem_addr_next = addr_r_reg;
                    mem_din_next  = result;
                    state_next    = ST_WR;
                end else if (timer_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_WR: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next      = (state_next != ST_IDLE);
        ops_valid_next = (state_next == ST_WAIT_RES);
        mem_we_next    = (state_next == ST_WR);
        done_next      = (state_next == ST_DONE);
    end

    // State, latched addresses and output registers; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            addr_b_reg    <= '0;
            addr_r_reg    <= '0;
            busy_reg      <= 1'b0;
            ops_valid_reg <= 1'b0;
            mem_we_reg    <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            mem_addr_reg  <= '0;
            mem_din_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            addr_b_reg    <= addr_b_next;
            addr_r_reg    <= addr_r_next;
            busy_reg      <= busy_next;
            ops_valid_reg <= ops_valid_next;
            mem_we_reg    <= mem_we_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            op_a_reg      <= op_a_next;
            op_b_reg      <= op_b_next;
            mem_addr_reg  <= mem_addr_next;
            mem_din_reg   <= mem_din_next;
        end
    end

    assign busy      = busy_reg;
    assign ops_valid = ops_valid_reg;
    assign mem_we    = mem_we_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign op_a      = op_a_reg;
    assign op_b      = op_b_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_din   = mem_din_reg;

endmodule

// File: tb/tb_dmem_operand_sequencer.sv
// Directed bench for the operand sequencer with a behavioural single-port RAM.
`timescale 1ns/1ps
module tb_dmem_operand_sequencer;
    import dmem_operand_sequencer_pkg::*;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          res_valid = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [AW-1:0] addr_b = '0;
    logic [AW-1:0] addr_r = '0;
    logic [DW-1:0] result = '0;
    logic          busy, ops_valid, mem_we, done, err;
    logic [DW-1:0] op_a, op_b, mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic [AW-1:0] mem_addr;

    // Behavioural RAM: registered read, write on mem_we, no reset.
    logic [DW-1:0] ram [ROW_D];
    logic          pre_en = 1'b0;
    logic [7:0]    pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] r;
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        logic [DW-1:0] res;
        int            delay;
        int            inject;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    dmem_operand_sequencer #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .addr_r    (addr_r),
        .busy      (busy),
        .op_a      (op_a),
        .op_b      (op_b),
        .ops_valid (ops_valid),
        .res_valid (res_valid),
        .result    (result),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout),
        .done      (done),
        .err       (err)
    );

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr[7:0]] <= mem_din;
        mem_dout <= ram[mem_addr[7:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    // inject bit0: second start during RD_B; bit1: stray res_valid during CAP_B;
    // bit2: res_valid together with start in IDLE.
    task automatic run_op(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] r, input logic [DW-1:0] va,
                          input logic [DW-1:0] vb, input logic [DW-1:0] res,
                          input int delay, input int inject);
        addr_a = a; addr_b = b; addr_r = r; start = 1'b1;
        if (inject[2]) begin res_valid = 1'b1; result = 16'hDEAD; end
        tick();                                   // RD_A
        start = 1'b0; res_valid = 1'b0;
        check({tag, " busy_rd_a"}, busy, 1);
        check({tag, " addr_rd_a"}, mem_addr, a);
        check({tag, " we_rd_a"}, mem_we, 0);
        tick();                                   // RD_B
        check({tag, " addr_rd_b"}, mem_addr, b);
        if (inject[0]) begin start = 1'b1; addr_a = 1; addr_b = 1; addr_r = 1; end
        tick();                                   // CAP_B
        start = 1'b0;
        check({tag, " ops_valid_early"}, ops_valid, 0);
        if (inject[1]) begin res_valid = 1'b1; result = 16'hDEAD; end
        tick();                                   // WAIT_RES, start+4
        res_valid = 1'b0;
        check({tag, " ops_valid"}, ops_valid, 1);
        check({tag, " op_a"}, op_a, va);
        check({tag, " op_b"}, op_b, vb);
        for (int i = 0; i < delay; i++) begin
            tick();
            check({tag, " still_waiting"}, {ops_valid, mem_we, done}, 3'b100);
        end
        res_valid = 1'b1; result = res;
        tick();                                   // WR
        res_valid = 1'b0; result = '0;
        check({tag, " we_wr"}, mem_we, 1);
        check({tag, " addr_wr"}, mem_addr, r);
        check({tag, " din_wr"}, mem_din, res);
        check({tag, " ops_valid_wr"}, ops_valid, 0);
        tick();                                   // DONE
        check({tag, " done"}, {done, err, mem_we, busy}, 4'b1001);
        check({tag, " ram_result"}, ram[r[7:0]], res);
        tick();                                   // IDLE
        check({tag, " idle"}, {busy, done}, 2'b00);
        $display("op %s a=%0d b=%0d r=%0d op_a=0x%0h op_b=0x%0h ram[r]=0x%0h",
                 tag, a, b, r, op_a, op_b, ram[r[7:0]]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a:3,  b:4,  r:9,   va:16'd5,    vb:16'd7,    res:16'd12,   delay:0, inject:0};
        vecs[1] = '{a:2,  b:2,  r:2,   va:16'h00FF, vb:16'h00FF, res:16'h01FE, delay:1, inject:0};
        vecs[2] = '{a:10, b:11, r:10,  va:16'hAAAA, vb:16'h5555, res:16'hFFFF, delay:3, inject:0};
        vecs[3] = '{a:255,b:0,  r:128, va:16'h8001, vb:16'h1234, res:16'h0000, delay:2, inject:0};
        vecs[4] = '{a:3,  b:4,  r:20,  va:16'd5,    vb:16'd7,    res:16'h0C0C, delay:0, inject:1};
        vecs[5] = '{a:12, b:13, r:14,  va:16'h0102, vb:16'h0304, res:16'h0406, delay:1, inject:6};

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("reset ctrl", {busy, ops_valid, mem_we, done, err}, 5'b0);
        check("reset ops", {op_a, op_b}, 32'h0);
        check("reset mem", {mem_addr, mem_din}, 32'h0);
        rst_n = 1'b1;
        tick();

        preload(8'd1, 16'h0BAD);

        // Stray strobe in IDLE
        res_valid = 1'b1; result = 16'h7777;
        tick();
        res_valid = 1'b0;
        check("stray idle", {busy, mem_we, done, ops_valid}, 4'b0);

        // Table-driven operations
        for (int v = 0; v < 6; v++) begin
            preload(vecs[v].r[7:0], 16'h5A5A);
            preload(vecs[v].a[7:0], vecs[v].va);
            preload(vecs[v].b[7:0], vecs[v].vb);
            run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].r,
                   vecs[v].va, vecs[v].vb, vecs[v].res, vecs[v].delay, vecs[v].inject);
        end
        check("busy reject ram1", ram[1], 16'h0BAD);

        // Timeout: no result ever arrives
        preload(8'd7, 16'hBEEF);
        preload(8'd5, 16'h0001);
        preload(8'd6, 16'h0002);
        addr_a = 5; addr_b = 6; addr_r = 7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();                   // WAIT_RES cycle 0
        check("to ops_valid", ops_valid, 1);
        for (int k = 0; k < TO - 1; k++) begin
            tick();
            check("to waiting", {done, mem_we, err}, 3'b000);
        end
        tick();                                   // DONE after TO cycles
        check("to done_err", {done, err, mem_we}, 3'b110);
        check("to ram_kept", ram[7], 16'hBEEF);
        tick();
        check("to idle", {busy, done, err}, 3'b000);
        $display("op timeout a=5 b=6 r=7 ram[r]=0x%0h", ram[7]);

        // Reset in WAIT_RES
        preload(8'd30, 16'h1111);
        addr_a = 3; addr_b = 4; addr_r = 30; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("rst_mid in_wait", ops_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid ctrl", {busy, ops_valid, mem_we, done, err}, 5'b0);
        check("rst_mid ops", {op_a, op_b}, 32'h0);
        check("rst_mid mem", {mem_addr, mem_din}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_mid no_done", {done, busy}, 2'b00);
        end
        check("rst_mid ram_kept", ram[30], 16'h1111);
        $display("op reset_mid a=3 b=4 r=30 ram[r]=0x%0h", ram[30]);
        run_op("after_rst", 3, 4, 30, 16'd5, 16'd7, 16'h2222, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
